// File: rtl/serial_cmp_pkg.sv
// Package shared by the serial comparator controller and its 2-bit slice.
//   SLICE_W  : width of one compare slice (2 bits)
//   state_t  : controller FSM states (IDLE / RUN / DONE)
//   result_t : one-hot greater / equal / less result
package serial_cmp_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic g;
        logic e;
        logic l;
    } result_t;

endpackage

// File: rtl/cmp2_slice.sv
// Purely combinational 2-bit unsigned magnitude compare (bit 1 is the MSB).
// Ports:
//   sa, sb : 2-bit slices of operand A and operand B
//   sg     : sa >  sb
//   se     : sa == sb
//   sl     : sa <  sb
// Exactly one of sg/se/sl is high for any input.
module cmp2_slice
    import serial_cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] sa,
    input  logic [SLICE_W-1:0] sb,
    output logic               sg,
    output logic               se,
    output logic               sl
);

    assign sg = (sa > sb);
    assign se = (sa == sb);
    assign sl = (sa < sb);

endmodule

// File: rtl/serial_comparator_ctrl.sv
// Serial magnitude comparator: walks a single 2-bit compare slice over a
// WIDTH-bit unsigned operand pair, most significant slice first, and
// returns one registered greater/equal/less result per request.
//
// Parameters:
//   WIDTH : operand width, even and >= 2 (N = WIDTH/2 slices)
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, accepted only while busy = 0
//   a, b       : operands, sampled on the accept edge only
//   busy       : request in flight; start is ignored while high
//   done       : one-cycle pulse, g/e/l valid from this cycle
//   g, e, l    : A > B, A == B, A < B (registered, held until next result)
//
// Build option:
//   SERIAL_CMP_EARLY_EXIT_EN defined  -> RUN stops at the first unequal slice
//                                        (latency 1..N cycles).
//   SERIAL_CMP_EARLY_EXIT_EN undefined -> all N slices are always examined;
//                                        the first unequal slice is kept as
//                                        a sticky decision (latency N).
module serial_comparator_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decided_q, decided_d;
    result_t          dec_q, dec_d;
    result_t          res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sg, se, sl;
    result_t          slice_res;
    result_t          dec_now;
    logic             finish;

    cmp2_slice u_slice (
        .sa (a_sh_q[WIDTH-1 -: SLICE_W]),
        .sb (b_sh_q[WIDTH-1 -: SLICE_W]),
        .sg (sg),
        .se (se),
        .sl (sl)
    );

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        dec_d     = dec_q;
        res_d     = res_q;
        busy_d    = busy_q;
        done_d    = done_q;

        slice_res = '{g: sg, e: se, l: sl};
        // Once a more significant slice has differed, lower slices no
        // longer matter; until then the current slice decides.
        dec_now   = decided_q ? dec_q : slice_res;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
        finish = (cnt_q == '0) || !se;
`else
        finish = (cnt_q == '0);
`endif

        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    cnt_d     = CNT_INIT;
                    decided_d = 1'b0;
                    dec_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q << SLICE_W;
                b_sh_d = b_sh_q << SLICE_W;
                cnt_d  = cnt_q - CNT_ONE;
                if (!decided_q && !se) begin
                    decided_d = 1'b1;
                    dec_d     = slice_res;
                end
                if (finish) begin
                    res_d   = dec_now;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            dec_q     <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            dec_q     <= dec_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign g    = res_q.g;
    assign e    = res_q.e;
    assign l    = res_q.l;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
module tb_serial_comparator_ctrl;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam int EE = 1;
`else
    localparam int EE = 0;
`endif

    localparam logic [2:0] R_G = 3'b100;
    localparam logic [2:0] R_E = 3'b010;
    localparam logic [2:0] R_L = 3'b001;

    typedef struct {
        logic [2:0] gel;
        int         k;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             g;
    logic             e;
    logic             l;

    exp_t sb[$];
    int   n_total;
    int   n_pass;
    int   run_cnt;
    int   done_cnt;
    int   exp_dones;
    logic prev_done;

    serial_comparator_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .g     (g),
        .e     (e),
        .l     (l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected latency: first differing slice with early exit, else N.
    function automatic int lat(input int k_first);
        return (EE != 0) ? k_first : N;
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_cnt   = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                exp_t x;
                done_cnt++;
                check("done_pulse_width", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    x = sb.pop_front();
                    check("gel", {29'd0, g, e, l}, {29'd0, x.gel});
                    check("latency", run_cnt, x.k);
                end
                run_cnt = 0;
            end else if (busy) begin
                run_cnt++;
            end else begin
                run_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (!busy) return;
        end
        check("wait_idle_timeout", 32'd1, 32'd0);
        $display("FAIL wait_idle_timeout: busy stuck high");
        $fatal(1, "timeout");
    endtask

    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic [2:0] gel, input int k);
        exp_t x;
        wait_idle();
        a     = ia;
        b     = ib;
        start = 1'b1;
        x.gel = gel;
        x.k   = k;
        sb.push_back(x);
        exp_dones++;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        exp_t x;
        n_total   = 0;
        n_pass    = 0;
        run_cnt   = 0;
        done_cnt  = 0;
        exp_dones = 0;
        prev_done = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;

        // 1. reset state, then idle after release
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_gel", {29'd0, g, e, l}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_gel", {29'd0, g, e, l}, 32'd0);

        // 2. equal operands
        issue(8'hA5, 8'hA5, R_E, N);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        // 3. first slice differs
        issue(8'hC0, 8'h80, R_G, lat(1));
        // 4. less-than in last slice, then back-to-back accept in first idle cycle
        issue(8'h01, 8'h02, R_L, N);
        issue(8'hFF, 8'h00, R_G, lat(1));

        // 5. start held high; a/b changed mid-flight
        wait_idle();
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        x.gel = R_L;
        x.k   = lat(2);
        sb.push_back(x);
        exp_dones++;
        @(negedge clk); #1;
        a = 8'h30;
        b = 8'h20;
        wait_idle();
        x.gel = R_G;
        x.k   = lat(2);
        sb.push_back(x);
        exp_dones++;
        @(negedge clk); #1;
        start = 1'b0;
        check("hold_second_accept_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        check("hold_no_extra_accept", {31'd0, busy}, 32'd0);
        check("hold_final_g", {29'd0, g, e, l}, {29'd0, R_G});

        // 6. reset during RUN slice 2
        issue(8'h00, 8'h00, R_E, N);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_gel", {29'd0, g, e, l}, 32'd0);
        sb.delete();
        exp_dones--;
        @(negedge clk); #1;
        rst_n = 1'b1;
        issue(8'hA5, 8'h5A, R_G, lat(1));
        wait_idle();
        repeat (2) @(negedge clk);
        #1;

        check("scoreboard_empty", sb.size(), 32'd0);
        check("done_count", done_cnt, exp_dones);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
